sv_motor_pwm: RTL and testbench
===============================

Name: sv_motor_pwm

Overview:
- Consumer end of the servo UI angle bus: takes the 8-bit angle `deg` (0..180) from the servo UI counter and generates the standard servo PWM drive.
- Frame period is fixed; high time is linear in angle.
- Angle is sampled only at frame start, so the output never carries glitched or runt pulses.
- Sits between the UI block and the servo output pin.

Parameters:
- CLK_DIV, 50, clk cycles per 1 us tick (50 MHz clk).
- PERIOD_US, 20000, frame length in us.
- MIN_PULSE_US, 500, high time at deg=0.
- US_PER_DEG, 11, extra high time per degree. Constraint: MIN_PULSE_US+180*US_PER_DEG < PERIOD_US.
- SLEW_DEG, 5, max change of the latched angle per frame. Used only with SV_MOTOR_SLEW_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run request.
- deg  in  8  commanded angle from the servo UI. Values >180 are clamped to 180.
- pwm  out  1  servo drive, registered.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.
- deg_lat  out  8  angle in use for the current frame.

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock.
- Reset values: pwm=0, frame_start=0, deg_lat=90, state=IDLE, div_cnt=0, us_cnt=0.
- Reset asserted mid-frame forces pwm=0 immediately, with no pulse completion.
- Tick: div_cnt counts 0..CLK_DIV-1 and wraps. tick=1 when div_cnt==CLK_DIV-1.
- us_cnt (width clog2(PERIOD_US)) advances on each tick and wraps at PERIOD_US-1.
- pulse_us = MIN_PULSE_US + deg_lat*US_PER_DEG, computed at full width with no truncation.
- State IDLE:
  - pwm=0, counters held at 0.
  - On a clk edge with en=1, go to RUN and perform a frame-start load.
- Frame-start load (on a single edge):
  - us_cnt<=0, div_cnt<=0.
  - deg_lat<=min(deg,180).
  - frame_start<=1 for exactly one cycle.
  - pwm<=1.
  - Latency: en rising → pwm=1 on the following clk edge (1 cycle).
- State RUN:
  - pwm=1 while us_cnt < pulse_us, else 0.
  - High time is exactly pulse_us*CLK_DIV cycles. Frame is exactly PERIOD_US*CLK_DIV cycles.
- End of frame (tick with us_cnt==PERIOD_US-1):
  - If en=1: perform a back-to-back frame-start load, with no gap cycle.
  - If en=0: go to IDLE, pwm=0.
- en dropping mid-frame: the current frame, including its pulse, completes normally. No truncated pulse.
- deg changes mid-frame: no effect until the next frame-start load.
- deg=0 still gives a MIN_PULSE_US pulse; the output is never flat while in RUN.
- deg=180 gives MIN_PULSE_US+180*US_PER_DEG.

Optional Feature:
- Macro: SV_MOTOR_SLEW_EN.
- Defined: at each frame-start load, deg_lat moves toward min(deg,180) by at most SLEW_DEG.
  - If the difference is ≤ SLEW_DEG, deg_lat becomes the target exactly.
  - Computed without underflow/overflow; deg_lat stays within 0..180.
  - The first frame after reset slews from 90.
- Undefined: deg_lat<=min(deg,180) directly; the SLEW_DEG parameter is ignored.

Test Plan:
- Defaults, rst_n low then high, en=1, deg=90 → frame_start after 1 cycle, pwm high 74500 cycles, frame 1000000 cycles, deg_lat=90.
- deg=0 then deg=180 (held for full frames) → pwm high 25000 and 124000 cycles respectively. deg=200 → deg_lat=180, high 124000.
- CLK_DIV=1, PERIOD_US=400: change deg 10→100 mid-pulse → current pulse unchanged (MIN+10*US_PER_DEG). Next frame uses 100.
- Drop en at us_cnt=5 during the pulse → pulse completes full width, pwm stays 0 after frame end, state IDLE, no frame_start. Re-raise en → frame_start 1 cycle later.
- rst_n pulsed low mid-pulse (asynchronous, between edges) → pwm=0 immediately, deg_lat=90. Restart behaves as in scenario 1.
- SV_MOTOR_SLEW_EN defined, SLEW_DEG=5, deg=100 from reset → deg_lat 95 then 100 on successive frames. deg=0 → 95,90,...,0 over 20 frames. Without the macro → deg_lat=0 on the next frame.

Source files
------------

// File: rtl/sv_motor_pwm.sv
// sv_motor_pwm: servo PWM generator driven by the UI angle bus.
// Fixed-length frames of PERIOD_US microseconds; the high time is
// MIN_PULSE_US + deg_lat*US_PER_DEG microseconds. The angle is latched only at
// frame start, so the output never carries runt or glitched pulses.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          run request; a frame in progress always completes
//   deg         commanded angle 0..180 (larger values clamp to 180)
//   pwm         registered servo drive
//   frame_start one-cycle pulse on the first cycle of each frame
//   deg_lat     angle in use for the current frame
// Optional macro SV_MOTOR_SLEW_EN: limits the change of deg_lat to SLEW_DEG
// per frame; when undefined deg_lat takes the clamped angle directly.
module sv_motor_pwm #(
    parameter int CLK_DIV      = 50,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_PULSE_US = 500,
    parameter int US_PER_DEG   = 11,
    parameter int SLEW_DEG     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] deg,
    output logic       pwm,
    output logic       frame_start,
    output logic [7:0] deg_lat
);
    localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int US_W  = $clog2(PERIOD_US);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [US_W-1:0]   us_cnt_q, us_cnt_d;
    logic              pwm_q, pwm_d, frame_start_q, frame_start_d;
    logic [7:0]        deg_lat_q, deg_lat_d, target;
    logic              tick, frame_end, load;
    logic [31:0]       pulse_us;

    if (MIN_PULSE_US + 180 * US_PER_DEG >= PERIOD_US || CLK_DIV < 1 || SLEW_DEG < 1) begin : g_bad_cfg
        $error("sv_motor_pwm: invalid parameter set");
    end

    always_comb begin
        tick      = div_cnt_q == DIV_W'(CLK_DIV - 1);
        frame_end = state_q == RUN && tick && us_cnt_q == US_W'(PERIOD_US - 1);
        load      = en && (state_q == IDLE || frame_end);
        state_d   = (load || (state_q == RUN && !frame_end)) ? RUN : IDLE;
        target    = deg > 8'd180 ? 8'd180 : deg;
`ifdef SV_MOTOR_SLEW_EN
        // 9-bit compares keep lat+SLEW_DEG from wrapping; results stay within 0..180
        deg_lat_d = !load ? deg_lat_q :
                    {1'b0, target} > {1'b0, deg_lat_q} + 9'(SLEW_DEG) ? deg_lat_q + 8'(SLEW_DEG) :
                    {1'b0, deg_lat_q} > {1'b0, target} + 9'(SLEW_DEG) ? deg_lat_q - 8'(SLEW_DEG) :
                    target;
`else
        deg_lat_d = load ? target : deg_lat_q;
`endif
        div_cnt_d = (state_d == IDLE || load || tick) ? '0 : div_cnt_q + DIV_W'(1);
        // frame wrap is covered by load (back-to-back) or the return to IDLE
        us_cnt_d  = (state_d == IDLE || load) ? '0 : tick ? us_cnt_q + US_W'(1) : us_cnt_q;
        // pwm is computed from the next counter/angle values so the registered
        // output lines up with the counters, giving exactly pulse_us*CLK_DIV cycles
        pulse_us      = 32'(MIN_PULSE_US) + 32'(deg_lat_d) * 32'(US_PER_DEG);
        pwm_d         = state_d == RUN && 32'(us_cnt_d) < pulse_us;
        frame_start_d = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            div_cnt_q     <= '0;
            us_cnt_q      <= '0;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
            deg_lat_q     <= 8'd90;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            us_cnt_q      <= us_cnt_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            deg_lat_q     <= deg_lat_d;
        end
    end

    assign pwm         = pwm_q;
    assign frame_start = frame_start_q;
    assign deg_lat     = deg_lat_q;
endmodule

// File: tb/tb_sv_motor_pwm.sv
// tb_sv_motor_pwm: frame-level reference model bench for sv_motor_pwm.
module tb_sv_motor_pwm;
    localparam int DIV  = 2;
    localparam int PER  = 200;
    localparam int MINP = 10;
    localparam int UPD  = 1;
    localparam int SLEW = 5;
    localparam int F    = PER * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] deg = 8'd90;
    logic       pwm, frame_start;
    logic [7:0] deg_lat;

    int checks = 0;
    int failures = 0;
    int lat_m = 90;

    sv_motor_pwm #(
        .CLK_DIV(DIV), .PERIOD_US(PER), .MIN_PULSE_US(MINP), .US_PER_DEG(UPD), .SLEW_DEG(SLEW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .deg(deg),
        .pwm(pwm), .frame_start(frame_start), .deg_lat(deg_lat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // angle the next frame-start load should latch, from the current one
    function automatic int next_lat(input int lat, input int d);
        int t;
        t = d > 180 ? 180 : d;
`ifdef SV_MOTOR_SLEW_EN
        if (t > lat + SLEW) return lat + SLEW;
        if (t < lat - SLEW) return lat - SLEW;
`endif
        return t;
    endfunction

    // Called on the negedge where frame_start is seen; walks the whole frame,
    // changes deg/en mid-pulse, and checks the start of the following frame.
    task automatic frame(input logic [7:0] nd, input bit ne);
        int hi = 0, glitch = 0, fs_extra = 0;
        bit low_seen = 0;
        check("deg_lat_start", deg_lat, lat_m);
        for (int i = 0; i < F; i++) begin
            if (i > 0) @(negedge clk);
            if (pwm) begin
                hi++;
                if (low_seen) glitch++;
            end else low_seen = 1;
            if (i > 0 && frame_start) fs_extra++;
            if (i == 10) begin
                deg = nd;
                en  = ne;
            end
        end
        check("pulse_cycles", hi, (MINP + lat_m * UPD) * DIV);
        check("pulse_glitch", glitch, 0);
        check("fs_in_frame", fs_extra, 0);
        check("deg_lat_hold", deg_lat, lat_m);
        @(negedge clk);
        check("fs_next", frame_start, ne);
        check("pwm_next", pwm, ne);
        if (ne) lat_m = next_lat(lat_m, nd);
    endtask

    task automatic idle_quiet(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pwm || frame_start) bad++;
        end
        check("idle_quiet", bad, 0);
    endtask

    task automatic start(input logic [7:0] d);
        deg = d;
        en  = 1'b1;
        @(negedge clk);
        check("start_latency_fs", frame_start, 1);
        check("start_pwm", pwm, 1);
        lat_m = next_lat(lat_m, d);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm, 0);
        check("rst_deg_lat", deg_lat, 90);
        rst_n = 1'b1;
        check("rst_fs", frame_start, 0);
        idle_quiet(5);
        start(8'd90);
        frame(8'd0, 1);
        frame(8'd180, 1);
        frame(8'd200, 1);
        for (int k = 0; k < 5; k++) frame(8'($urandom_range(0, 255)), 1);
        frame(8'($urandom_range(0, 180)), 0);
        idle_quiet(2 * F);
        start(8'($urandom_range(0, 180)));
        frame(8'($urandom_range(0, 255)), 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm", pwm, 0);
        check("async_rst_deg_lat", deg_lat, 90);
        check("async_rst_fs", frame_start, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lat_m = 90;
        idle_quiet(4);
        start(8'd100);
        frame(8'd100, 1);
        for (int k = 0; k < 20; k++) frame(8'd0, 1);
        frame(8'd0, 0);
        idle_quiet(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
